// File: rtl/uart_core_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_tx_serializer_if
// Brief    : Handshake/config bundle between protocol, config and user layers
//            and the UART transmit serializer core.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_core_tx_serializer_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
);
    logic              PROT_CORE_ctrl_Txen;
    logic              PROT_CORE_ctrl_empty;
    logic              USR_CORE_cts;
    logic [DATA_W-1:0] CFG_CORE_tx_data;
    logic [DIV_W-1:0]  CFG_CORE_baud_div;
    logic              CFG_CORE_parity_en;
    logic              CFG_CORE_parity_odd;
    logic              CORE_CFG_r_en;
    logic              CORE_USR_txd;
    logic              CORE_PROT_busy;

    modport master (
        output PROT_CORE_ctrl_Txen,
        output PROT_CORE_ctrl_empty,
        output USR_CORE_cts,
        output CFG_CORE_tx_data,
        output CFG_CORE_baud_div,
        output CFG_CORE_parity_en,
        output CFG_CORE_parity_odd,
        input  CORE_CFG_r_en,
        input  CORE_USR_txd,
        input  CORE_PROT_busy
    );

    modport slave (
        input  PROT_CORE_ctrl_Txen,
        input  PROT_CORE_ctrl_empty,
        input  USR_CORE_cts,
        input  CFG_CORE_tx_data,
        input  CFG_CORE_baud_div,
        input  CFG_CORE_parity_en,
        input  CFG_CORE_parity_odd,
        output CORE_CFG_r_en,
        output CORE_USR_txd,
        output CORE_PROT_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_core_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_tx_serializer
// Brief    : UART frame serializer: start, LSB-first data, optional parity,
//            one stop bit, with back-to-back frames and cts-gated loading.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_tx_serializer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input wire                         glb_clk,
    input wire                         glb_rstn,
    uart_core_tx_serializer_if.slave   bus
);

    localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [c_BIT_W-1:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [DIV_W-1:0]    r_baud_cnt, w_baud_cnt_nxt;
    logic [DIV_W-1:0]    r_div,      w_div_nxt;
    logic [DATA_W-1:0]   r_shift,    w_shift_nxt;
    logic                r_par_en,   w_par_en_nxt;
    logic                r_par_bit,  w_par_bit_nxt;
    logic                r_last,     w_last_nxt;
    logic                r_txd,      w_txd_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_run;
    logic                w_bit_end;
    logic                w_load;
    logic [DATA_W-1:0]   w_shift_dn;

    // Loading is held off for the first edge after reset release.
    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) r_run <= 1'b0;
        else           r_run <= 1'b1;
    end

    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_div      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_last     <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_div      <= w_div_nxt;
            r_shift    <= w_shift_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_last     <= w_last_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_bit_end  = (r_baud_cnt == r_div);
        w_shift_dn = r_shift >> 1;
        w_load     = r_run && bus.PROT_CORE_ctrl_Txen && bus.USR_CORE_cts &&
                     ((r_state == S_IDLE) ||
                      ((r_state == S_STOP) && w_bit_end && !r_last));

        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        w_div_nxt      = r_div;
        w_shift_nxt    = r_shift;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_last_nxt     = r_last;
        w_txd_nxt      = r_txd;

        // txd is registered, so it is driven from the state being entered.
        case (r_state)
            S_IDLE: begin
                w_baud_cnt_nxt = '0;
                w_txd_nxt      = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                    w_txd_nxt     = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                        w_txd_nxt   = r_par_en ? r_par_bit : 1'b1;
                    end else begin
                        w_shift_nxt   = w_shift_dn;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_txd_nxt     = w_shift_dn[0];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_txd_nxt   = 1'b1;
                    w_last_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = S_START;
            w_bit_cnt_nxt  = '0;
            w_baud_cnt_nxt = '0;
            w_div_nxt      = bus.CFG_CORE_baud_div;
            w_shift_nxt    = bus.CFG_CORE_tx_data;
            w_par_en_nxt   = bus.CFG_CORE_parity_en;
            w_par_bit_nxt  = (^bus.CFG_CORE_tx_data) ^ bus.CFG_CORE_parity_odd;
            w_last_nxt     = bus.PROT_CORE_ctrl_empty;
            w_txd_nxt      = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.CORE_CFG_r_en  = w_load;
    assign bus.CORE_USR_txd   = r_txd;
    assign bus.CORE_PROT_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_core_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core_tx_serializer
// Brief    : Directed and random stimulus against a frame-queue line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_tx_serializer;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;
    int   n_ren;
    int   base;

    uart_core_tx_serializer_if #(.DATA_W(8), .DIV_W(16)) u_if ();

    uart_core_tx_serializer #(.DATA_W(8), .DIV_W(16)) u_dut (
        .glb_clk  (clk),
        .glb_rstn (rstn),
        .bus      (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected line level for the current and every future cycle of the frames.
    bit q[$];
    bit m_last;
    bit m_run;

    task automatic push_bit(input bit b, input int n);
        for (int k = 0; k < n; k++) q.push_back(b);
    endtask

    always @(negedge clk) begin
        bit e_load;
        bit e_txd;
        bit e_busy;
        int n;
        logic [7:0] d;
        if (!rstn) begin
            q.delete();
            m_last = 1'b0;
            m_run  = 1'b0;
            chk("rst_ren",  u_if.CORE_CFG_r_en,  1'b0);
            chk("rst_txd",  u_if.CORE_USR_txd,   1'b1);
            chk("rst_busy", u_if.CORE_PROT_busy, 1'b0);
        end else begin
            e_load = m_run && u_if.PROT_CORE_ctrl_Txen && u_if.USR_CORE_cts &&
                     ((q.size() == 0) || ((q.size() == 1) && !m_last));
            e_txd  = (q.size() != 0) ? q[0] : 1'b1;
            e_busy = (q.size() != 0);
            chk("r_en", u_if.CORE_CFG_r_en,  e_load);
            chk("txd",  u_if.CORE_USR_txd,   e_txd);
            chk("busy", u_if.CORE_PROT_busy, e_busy);
            if (u_if.CORE_CFG_r_en) n_ren++;
            if (q.size() != 0) void'(q.pop_front());
            if (e_load) begin
                n = int'(u_if.CFG_CORE_baud_div) + 1;
                d = u_if.CFG_CORE_tx_data;
                push_bit(1'b0, n);
                for (int i = 0; i < 8; i++) push_bit(d[i], n);
                if (u_if.CFG_CORE_parity_en)
                    push_bit(($countones(d) % 2 == 1) ^ u_if.CFG_CORE_parity_odd, n);
                push_bit(1'b1, n);
                m_last = u_if.PROT_CORE_ctrl_empty;
            end else if (q.size() == 0) begin
                m_last = 1'b0;
            end
            m_run = 1'b1;
        end
    end

    initial begin
        n_vec = 0; n_err = 0; n_ren = 0;
        rstn = 1'b0;
        u_if.PROT_CORE_ctrl_Txen  = 1'b0;
        u_if.PROT_CORE_ctrl_empty = 1'b0;
        u_if.USR_CORE_cts         = 1'b0;
        u_if.CFG_CORE_tx_data     = '0;
        u_if.CFG_CORE_baud_div    = '0;
        u_if.CFG_CORE_parity_en   = 1'b0;
        u_if.CFG_CORE_parity_odd  = 1'b0;
        step(3);
        rstn = 1'b1;
        step(3);

        // Single byte A5, N = 4
        base = n_ren;
        u_if.CFG_CORE_baud_div = 16'd3;
        u_if.CFG_CORE_tx_data  = 8'hA5;
        u_if.USR_CORE_cts      = 1'b1;
        u_if.PROT_CORE_ctrl_Txen  = 1'b1;
        u_if.PROT_CORE_ctrl_empty = 1'b1;
        step(1);
        u_if.PROT_CORE_ctrl_Txen  = 1'b0;
        u_if.PROT_CORE_ctrl_empty = 1'b0;
        step(45);
        chk("single_loads", n_ren - base, 1);
        chk("single_idle",  u_if.CORE_PROT_busy, 1'b0);

        // Back-to-back 01, 02, FF with N = 1
        base = n_ren;
        u_if.CFG_CORE_baud_div = 16'd0;
        for (int i = 0; i < 30; i++) begin
            u_if.CFG_CORE_tx_data     = (i < 10) ? 8'h01 : (i < 20) ? 8'h02 : 8'hFF;
            u_if.PROT_CORE_ctrl_empty = (i >= 20);
            u_if.PROT_CORE_ctrl_Txen  = (i <= 20);
            step(1);
        end
        u_if.PROT_CORE_ctrl_empty = 1'b0;
        step(15);
        chk("b2b_loads", n_ren - base, 3);

        // Parity on 07: even then odd
        for (int p = 0; p < 2; p++) begin
            base = n_ren;
            u_if.CFG_CORE_baud_div    = 16'd1;
            u_if.CFG_CORE_parity_en   = 1'b1;
            u_if.CFG_CORE_parity_odd  = p[0];
            u_if.CFG_CORE_tx_data     = 8'h07;
            u_if.PROT_CORE_ctrl_Txen  = 1'b1;
            u_if.PROT_CORE_ctrl_empty = 1'b1;
            step(1);
            u_if.PROT_CORE_ctrl_Txen  = 1'b0;
            u_if.PROT_CORE_ctrl_empty = 1'b0;
            step(25);
            chk("parity_loads", n_ren - base, 1);
        end
        u_if.CFG_CORE_parity_en = 1'b0;

        // Flow control: cts held low, then released, then dropped mid-frame
        base = n_ren;
        u_if.USR_CORE_cts        = 1'b0;
        u_if.PROT_CORE_ctrl_Txen = 1'b1;
        u_if.CFG_CORE_baud_div   = 16'd0;
        u_if.CFG_CORE_tx_data    = 8'($urandom);
        step(20);
        chk("cts_wait", n_ren - base, 0);
        u_if.USR_CORE_cts = 1'b1;
        step(1);
        chk("cts_load", n_ren - base, 1);
        step(3);
        u_if.USR_CORE_cts = 1'b0;
        step(30);
        chk("cts_drop", n_ren - base, 1);
        u_if.PROT_CORE_ctrl_Txen = 1'b0;
        u_if.USR_CORE_cts        = 1'b1;
        step(2);

        // Reset during data bit 3, then a fresh frame
        u_if.CFG_CORE_baud_div    = 16'd3;
        u_if.CFG_CORE_tx_data     = 8'($urandom);
        u_if.PROT_CORE_ctrl_Txen  = 1'b1;
        u_if.PROT_CORE_ctrl_empty = 1'b1;
        step(1);
        u_if.PROT_CORE_ctrl_Txen  = 1'b0;
        u_if.PROT_CORE_ctrl_empty = 1'b0;
        step(17);
        rstn = 1'b0;
        #1;
        chk("rst_mid_txd",  u_if.CORE_USR_txd,   1'b1);
        chk("rst_mid_busy", u_if.CORE_PROT_busy, 1'b0);
        step(2);
        rstn = 1'b1;
        step(3);
        base = n_ren;
        u_if.PROT_CORE_ctrl_Txen  = 1'b1;
        u_if.PROT_CORE_ctrl_empty = 1'b1;
        step(1);
        u_if.PROT_CORE_ctrl_Txen  = 1'b0;
        u_if.PROT_CORE_ctrl_empty = 1'b0;
        step(45);
        chk("post_rst_loads", n_ren - base, 1);

        // Divisor changed 3 -> 7 mid-frame
        base = n_ren;
        u_if.CFG_CORE_baud_div   = 16'd3;
        u_if.CFG_CORE_tx_data    = 8'($urandom);
        u_if.PROT_CORE_ctrl_Txen = 1'b1;
        step(10);
        u_if.CFG_CORE_baud_div    = 16'd7;
        u_if.CFG_CORE_tx_data     = 8'($urandom);
        u_if.PROT_CORE_ctrl_empty = 1'b1;
        step(32);
        u_if.PROT_CORE_ctrl_Txen  = 1'b0;
        u_if.PROT_CORE_ctrl_empty = 1'b0;
        step(90);
        chk("cfg_loads", n_ren - base, 2);

        // Random traffic with occasional resets
        repeat (3000) begin
            u_if.PROT_CORE_ctrl_Txen  = ($urandom_range(0, 7) != 0);
            u_if.USR_CORE_cts         = ($urandom_range(0, 5) != 0);
            u_if.PROT_CORE_ctrl_empty = ($urandom_range(0, 3) == 0);
            u_if.CFG_CORE_tx_data     = 8'($urandom);
            u_if.CFG_CORE_baud_div    = 16'($urandom_range(0, 3));
            u_if.CFG_CORE_parity_en   = 1'($urandom);
            u_if.CFG_CORE_parity_odd  = 1'($urandom);
            rstn                      = ($urandom_range(0, 399) != 0);
            step(1);
        end
        rstn = 1'b1;
        u_if.PROT_CORE_ctrl_Txen = 1'b0;
        step(60);
        chk("final_idle", u_if.CORE_PROT_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_core_tx_serializer.md
UART_CORE_TX_SERIALIZER -- requirements
Module: uart_core_tx_serializer

Interface
REQ-001 Parameter DATA_W, default 8: frame payload width in bits.
REQ-002 Parameter DIV_W, default 16: baud divisor width.
REQ-003 glb_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 glb_rstn  input  1  asynchronous, active-low reset.
REQ-005 PROT_CORE_ctrl_Txen  input  1  protocol layer requests transmission.
REQ-006 PROT_CORE_ctrl_empty  input  1  with CORE_CFG_r_en high: the byte being loaded is the last of the transfer.
REQ-007 USR_CORE_cts  input  1  clear-to-send, active high; gates loading only.
REQ-008 CFG_CORE_tx_data  input  DATA_W  byte offered by the config layer, first-word-fall-through.
REQ-009 CFG_CORE_baud_div  input  DIV_W  bit period minus one, in glb_clk cycles.
REQ-010 CFG_CORE_parity_en  input  1  1 = insert parity bit.
REQ-011 CFG_CORE_parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-012 CORE_CFG_r_en  output  1  one-cycle pulse; CFG_CORE_tx_data consumed this cycle.
REQ-013 CORE_USR_txd  output  1  serial line, registered, idle high.
REQ-014 CORE_PROT_busy  output  1  high while a frame is on the line.

Function
REQ-015 States: IDLE, START, DATA, PARITY, STOP; the state machine, bit counter, baud counter and shift register are all registered.
REQ-016 Load condition: (IDLE and Txen and cts) or (last cycle of STOP and Txen and cts and last_flag=0).
REQ-017 On a load cycle the block asserts CORE_CFG_r_en for exactly that cycle and captures tx_data, baud_div, parity_en and parity_odd.
REQ-018 Captured configuration is held for the whole frame; config changes mid-frame take effect at the next load only.
REQ-019 Bit period N = captured baud_div + 1 cycles; baud_div = 0 gives N = 1.
REQ-020 CORE_USR_txd goes low on the cycle after the load and holds each bit for exactly N cycles.
REQ-021 Frame order: start (0), DATA_W data bits LSB first, parity bit if enabled, one stop bit (1).
REQ-022 Parity bit = XOR of the data bits, inverted when parity_odd = 1.
REQ-023 Frame length is (DATA_W+2)*N cycles without parity and (DATA_W+3)*N cycles with parity.
REQ-024 When the load condition holds on the last STOP cycle, the next START follows with no idle gap.
REQ-025 Otherwise the block returns to IDLE after STOP, with txd = 1 and busy = 0.
REQ-026 last_flag is set on a load cycle when PROT_CORE_ctrl_empty = 1, and cleared on entry to IDLE.
REQ-027 While last_flag = 1, the block makes no further load at the end of STOP.
REQ-028 Txen or cts falling mid-frame does not abort the frame; it only suppresses the next load.
REQ-029 cts low in IDLE with Txen high: the block waits, with no r_en and txd = 1.
REQ-030 CORE_PROT_busy is high from the cycle after a load until the last STOP cycle of the final frame, inclusive.
REQ-031 CORE_CFG_r_en is never asserted in two consecutive cycles.

Reset
REQ-032 Asserting glb_rstn low immediately sets: state IDLE, CORE_USR_txd = 1, CORE_CFG_r_en = 0, CORE_PROT_busy = 0, counters 0, last_flag 0, shift register 0.
REQ-033 Reset mid-frame abandons the frame; no r_en is issued after reset until a new load condition is met.
REQ-034 Reset release is synchronous to glb_clk and has no effect on the first post-release cycle.

Verification
REQ-035 Single byte: div=3, parity off, tx_data=8'hA5, Txen=1 for one cycle with empty=1 on the r_en cycle.
  Response: one r_en pulse; txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles); then IDLE with busy = 0.
REQ-036 Back-to-back: 3 bytes 8'h01, 8'h02, 8'hFF, div=0, Txen held, empty=1 on the third r_en.
  Response: 3 r_en pulses exactly 10 cycles apart; 30 contiguous bit cycles; no fourth load.
REQ-037 Parity: tx_data=8'h07.
  Response with even parity: parity bit = 1, frame = 11*N cycles.
  Response with odd parity: parity bit = 0.
REQ-038 Flow control: cts=0 with Txen=1 for 20 cycles, then cts=1.
  Response: no r_en and txd = 1 during the 20 cycles; load on the first cycle cts=1.
  Second case: cts dropped mid-frame; the frame completes and no next load occurs.
REQ-039 Reset: glb_rstn pulsed low during the DATA bit 3 window.
  Response: txd = 1 and busy = 0 in the same cycle; the next frame starts only after a fresh load with correct timing.
REQ-040 Config change: baud_div changed from 3 to 7 mid-frame.
  Response: the current frame keeps N = 4; the following frame uses N = 8.
